dram_arbiter: RTL and testbench

Two-master arbiter for the single-port data RAM in the MIPS top level. It shares the RAM between the CPU data port (master 0) and a DMA/debug loader (master 1). The CPU has default priority, and a starvation counter guarantees DMA progress. The block issues at most one RAM access per cycle, returns read data one cycle after grant, and drives a stall to the CPU while the CPU's request is not granted.

---
 rtl/dram_arbiter.sv | 119 +++++++++++
 tb/tb_dram_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dram_arbiter.sv
// dram_arbiter: shares the single-port data RAM between the CPU data port
// (default priority) and a DMA/debug loader, with a starvation guard for DMA.
module dram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_stall,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_wen,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        ram_we,
  output logic [29:0] ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  logic [3:0]  starve_q, starve_d;
  logic        tag_v_q, tag_v_d;
  logic        tag_id_q, tag_id_d;
  logic [29:0] addr_q;
  logic [31:0] din_q;
  logic [31:0] cpu_rdata_q, dma_rdata_q;

  logic        contended;
  logic        any_gnt;
  logic        sel_wen;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

  // Combinational arbitration: CPU wins contention unless DMA has starved.
  always_comb begin
    contended = cpu_req & dma_req;
    dma_gnt   = dma_req & (~cpu_req | (starve_q == Limit));
    cpu_gnt   = cpu_req & ~dma_gnt;
    cpu_stall = cpu_req & ~cpu_gnt;
    any_gnt   = cpu_gnt | dma_gnt;
    sel_wen   = dma_gnt ? dma_wen   : cpu_wen;
    sel_addr  = dma_gnt ? dma_addr  : cpu_addr;
    sel_wdata = dma_gnt ? dma_wdata : cpu_wdata;
  end

  // RAM port: drive the granted master, otherwise hold the last address/data.
  always_comb begin
    ram_we   = any_gnt & sel_wen & ~rst;
    ram_addr = any_gnt ? sel_addr[31:2] : addr_q;
    ram_din  = any_gnt ? sel_wdata : din_q;
  end

  // Next-state for the starvation counter and the read owner tag.
  always_comb begin
    starve_d = starve_q;
    if (!dma_req || dma_gnt) begin
      starve_d = 4'd0;
    end else if (contended && cpu_gnt && starve_q != Limit) begin
      starve_d = starve_q + 4'd1;
    end
    tag_v_d  = any_gnt & ~sel_wen;
    tag_id_d = dma_gnt;
  end

  // Read completion: data comes straight from the RAM in the rvalid cycle,
  // then the per-master register holds it until that master's next read.
  always_comb begin
    cpu_rvalid = tag_v_q & ~tag_id_q;
    dma_rvalid = tag_v_q & tag_id_q;
    cpu_rdata  = cpu_rvalid ? ram_dout : cpu_rdata_q;
    dma_rdata  = dma_rvalid ? ram_dout : dma_rdata_q;
  end

  // Arbitration state and read owner tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= 4'd0;
      tag_v_q  <= 1'b0;
      tag_id_q <= 1'b0;
    end else begin
      starve_q <= starve_d;
      tag_v_q  <= tag_v_d;
      tag_id_q <= tag_id_d;
    end
  end

  // Hold registers for the RAM address/data bus when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= 30'd0;
      din_q  <= 32'd0;
    end else if (any_gnt) begin
      addr_q <= sel_addr[31:2];
      din_q  <= sel_wdata;
    end
  end

  // Capture completed read data into the owning master's register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rdata_q <= 32'd0;
      dma_rdata_q <= 32'd0;
    end else begin
      if (cpu_rvalid) cpu_rdata_q <= ram_dout;
      if (dma_rvalid) dma_rdata_q <= ram_dout;
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed and random traffic against a transaction-level
// model of the arbiter and a write-first synchronous RAM.
module tb_dram_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 0, cpu_wen = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0;
  logic        dma_req = 0, dma_wen = 0;
  logic [31:0] dma_addr = 0, dma_wdata = 0;
  logic        cpu_gnt, cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rdata;
  logic        ram_we;
  logic [29:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout = 0;

  int checks = 0;
  int errors = 0;

  dram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_wen(dma_wen),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Write-first single-port RAM.
  logic [31:0] ram [int unsigned];
  always @(posedge clk) begin
    if (ram_we) begin
      ram[int'(ram_addr)] = ram_din;
      ram_dout <= ram_din;
    end else begin
      ram_dout <= ram.exists(int'(ram_addr)) ? ram[int'(ram_addr)] : 32'd0;
    end
  end

  // Reference model state.
  logic [31:0] mem [int unsigned];
  int          wait_cnt = 0;
  logic        pc = 0, pd = 0;
  logic [31:0] pcd = 0, pdd = 0, hc = 0, hd = 0;
  logic [29:0] last_a = 0;
  logic        got_c, got_d;

  function automatic logic [31:0] mrd(input logic [29:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_cpu(input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
    cpu_req = r; cpu_wen = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_dma(input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
    dma_req = r; dma_wen = w; dma_addr = a; dma_wdata = d;
  endtask

  // One clock: check outputs mid-cycle, then advance the model over the edge.
  task automatic step();
    logic cg, dg, gw, g;
    logic [31:0] ga, gd;
    @(negedge clk);
    if (rst) begin
      wait_cnt = 0; pc = 0; pd = 0;
      hc = 0; hd = 0; last_a = 0;
    end
    dg = dma_req && (!cpu_req || wait_cnt == LIMIT);
    cg = cpu_req && !dg;
    g  = cg | dg;
    gw = dg ? dma_wen : cpu_wen;
    ga = dg ? dma_addr : cpu_addr;
    gd = dg ? dma_wdata : cpu_wdata;
    chk("cpu_gnt", 32'(cpu_gnt), 32'(cg));
    chk("dma_gnt", 32'(dma_gnt), 32'(dg));
    chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req & ~cg));
    chk("ram_we", 32'(ram_we), 32'(g & gw & ~rst));
    chk("ram_addr", 32'(ram_addr), 32'(g ? ga[31:2] : last_a));
    if (g) chk("ram_din", ram_din, gd);
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(pc));
    chk("dma_rvalid", 32'(dma_rvalid), 32'(pd));
    chk("cpu_rdata", cpu_rdata, pc ? pcd : hc);
    chk("dma_rdata", dma_rdata, pd ? pdd : hd);
    got_c = cg;
    got_d = dg;
    if (!rst) begin
      if (pc) hc = pcd;
      if (pd) hd = pdd;
      pc = cg & ~gw;
      pd = dg & ~gw;
      if (g && !gw) begin
        if (cg) pcd = mrd(ga[31:2]);
        else    pdd = mrd(ga[31:2]);
      end
      if (g && gw) mem[int'(ga[31:2])] = gd;
      if (g) last_a = ga[31:2];
      wait_cnt = (!dma_req || dg) ? 0 : wait_cnt + 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ndma;
    logic [LIMIT:0] pat;

    // Reset state.
    step();
    step();
    rst = 1'b0;
    step();

    // CPU-only write then read of 0x100.
    set_cpu(1, 1, 32'h100, 32'hDEADBEEF);
    step();
    set_cpu(1, 0, 32'h100, 32'h0);
    step();
    set_cpu(0, 0, 32'h0, 32'h0);
    step();
    chk("cpu_rdata_hold", cpu_rdata, 32'hDEADBEEF);
    chk("dma_rdata_idle", dma_rdata, 32'h0);

    // Continuous contention: 4 CPU grants then 1 DMA grant, repeating.
    set_cpu(1, 0, 32'h200, 32'h0);
    set_dma(1, 0, 32'h300, 32'h0);
    ndma = 0;
    pat  = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (got_d) ndma++;
      if (i < LIMIT + 1) pat[i] = got_d;
    end
    chk("dma_grants_10", 32'(ndma), 32'd2);
    chk("first_dma_slot", 32'(pat), 32'(1 << LIMIT));
    set_cpu(0, 0, 0, 0);
    set_dma(0, 0, 0, 0);
    step();

    // Alternating reads of 0x0 and 0x4.
    set_cpu(1, 1, 32'h0, 32'h11);
    step();
    set_cpu(1, 1, 32'h4, 32'h22);
    step();
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        set_cpu(1, 0, 32'h0, 0);
        set_dma(0, 0, 0, 0);
      end else begin
        set_cpu(0, 0, 0, 0);
        set_dma(1, 0, 32'h4, 0);
      end
      step();
    end
    set_dma(0, 0, 0, 0);
    step();
    chk("alt_cpu_rdata", cpu_rdata, 32'h11);
    chk("alt_dma_rdata", dma_rdata, 32'h22);

    // Misaligned write to 0x103 lands on word 0x40.
    set_cpu(1, 1, 32'h103, 32'hCAFE0103);
    #1;
    chk("misaligned_addr", 32'(ram_addr), 32'h40);
    step();
    set_cpu(1, 0, 32'h100, 0);
    step();
    set_cpu(0, 0, 0, 0);
    step();
    chk("misaligned_rd", cpu_rdata, 32'hCAFE0103);

    // Reset in the cycle after a CPU read grant.
    set_cpu(1, 0, 32'h100, 0);
    step();
    set_cpu(0, 0, 0, 0);
    rst = 1'b1;
    step();
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_rdata", cpu_rdata, 32'd0);

    // DMA starves, drops request, then contention restarts with CPU.
    set_cpu(1, 0, 32'h10, 0);
    set_dma(1, 0, 32'h20, 0);
    for (int i = 0; i < LIMIT; i++) step();
    set_dma(0, 0, 0, 0);
    step();
    set_dma(1, 0, 32'h20, 0);
    step();
    chk("drop_clears_starve", 32'(got_c), 32'd1);
    set_cpu(0, 0, 0, 0);
    set_dma(0, 0, 0, 0);
    step();

    // Random traffic; masters hold their request until granted.
    for (int i = 0; i < 400; i++) begin
      if (!cpu_req || got_c || $urandom_range(0, 7) == 0)
        set_cpu(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 63), $urandom);
      if (!dma_req || got_d || $urandom_range(0, 7) == 0)
        set_dma(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                $urandom_range(0, 63), $urandom);
      step();
    end
    set_cpu(0, 0, 0, 0);
    set_dma(0, 0, 0, 0);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
